// File: rtl/cfg_rst_sequencer_if.sv
// cfg_rst_sequencer_if: run request, delay and config in; shadow config, sequenced resets and status out
interface cfg_rst_sequencer_if #(
  parameter int NUM_STAGES = 4,
  parameter int DLY_WIDTH  = 16,
  parameter int CFG_WIDTH  = 96
);
  logic                  run_req;
  logic [DLY_WIDTH-1:0]  dly;
  logic [CFG_WIDTH-1:0]  cfg_in;
  logic [CFG_WIDTH-1:0]  cfg_out;
  logic [NUM_STAGES-1:0] nreset_out;
  logic                  running;
  logic                  busy;
  modport master (output run_req, dly, cfg_in, input cfg_out, nreset_out, running, busy);
  modport slave  (input run_req, dly, cfg_in, output cfg_out, nreset_out, running, busy);
endinterface

// File: rtl/cfg_rst_sequencer.sv
// cfg_rst_sequencer: ordered release/assert of active-low stage resets with shadowed config
// ports: aclk, areset (async, active-high); bus.slave carries run_req, dly, cfg_in in and
// cfg_out, nreset_out (bit 0 released first), running (RUN), busy (UP/DOWN) out
module cfg_rst_sequencer #(
  parameter int NUM_STAGES = 4,
  parameter int DLY_WIDTH  = 16,
  parameter int CFG_WIDTH  = 96
) (
  input logic                aclk,
  input logic                areset,
  cfg_rst_sequencer_if.slave bus
);
  localparam int IW = NUM_STAGES > 1 ? $clog2(NUM_STAGES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_STAGES - 1);
  localparam logic [1:0] S_OFF = 2'd0, S_UP = 2'd1, S_RUN = 2'd2, S_DOWN = 2'd3;
  logic [1:0]            state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DLY_WIDTH-1:0]  cnt_q, cnt_d, dly_l_q, dly_l_d;
  logic [NUM_STAGES-1:0] nrst_q, nrst_d;
  logic [CFG_WIDTH-1:0]  cfg_q, cfg_d;
  logic                  running_q, running_d, busy_q, busy_d;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    dly_l_d = dly_l_q;
    nrst_d  = nrst_q;
    cfg_d   = cfg_q;
    case (state_q)
      S_OFF: begin
        cfg_d = bus.cfg_in;
        if (bus.run_req) begin
          state_d = S_UP;
          dly_l_d = bus.dly;
          cnt_d   = bus.dly;
          idx_d   = '0;
        end
      end
      S_UP:
        // in UP exactly idx stages are released, so the highest set bit is idx-1
        if (!bus.run_req) begin
          cnt_d   = dly_l_q;
          state_d = idx_q == '0 ? S_OFF : S_DOWN;
          idx_d   = idx_q == '0 ? idx_q : idx_q - 1'b1;
        end else if (cnt_q == '0) begin
          nrst_d[idx_q] = 1'b1;
          cnt_d         = dly_l_q;
          state_d       = idx_q == LAST ? S_RUN : S_UP;
          idx_d         = idx_q == LAST ? idx_q : idx_q + 1'b1;
        end else
          cnt_d = cnt_q - 1'b1;
      S_RUN:
        if (!bus.run_req) begin
          state_d = S_DOWN;
          dly_l_d = bus.dly;
          cnt_d   = bus.dly;
          idx_d   = LAST;
        end
      default:
        if (cnt_q == '0) begin
          nrst_d[idx_q] = 1'b0;
          cnt_d         = dly_l_q;
          state_d       = idx_q == '0 ? S_OFF : S_DOWN;
          idx_d         = idx_q == '0 ? idx_q : idx_q - 1'b1;
        end else
          cnt_d = cnt_q - 1'b1;
    endcase
    running_d = state_d == S_RUN;
    busy_d    = state_d == S_UP || state_d == S_DOWN;
  end
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      state_q   <= S_OFF;
      idx_q     <= '0;
      cnt_q     <= '0;
      dly_l_q   <= '0;
      nrst_q    <= '0;
      cfg_q     <= '0;
      running_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      dly_l_q   <= dly_l_d;
      nrst_q    <= nrst_d;
      cfg_q     <= cfg_d;
      running_q <= running_d;
      busy_q    <= busy_d;
    end
  assign bus.cfg_out    = cfg_q;
  assign bus.nreset_out = nrst_q;
  assign bus.running    = running_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_cfg_rst_sequencer.sv
// tb_cfg_rst_sequencer: directed bring-up, tear-down, abort, shadow config, delay extremes and async reset
module tb_cfg_rst_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  localparam logic [95:0] CFG_A = 96'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5;
  localparam logic [95:0] CFG_B = 96'h1234_5678_9ABC_DEF0_0F1E_2D3C;
  cfg_rst_sequencer_if #(.NUM_STAGES(4), .DLY_WIDTH(16), .CFG_WIDTH(96)) bus ();
  cfg_rst_sequencer #(.NUM_STAGES(4), .DLY_WIDTH(16), .CFG_WIDTH(96)) dut (
    .aclk(clk), .areset(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  function automatic logic thermo(input logic [3:0] x);
    logic [4:0] t;
    t = {1'b0, x} + 5'd1;
    return (t[3:0] & x) == 4'd0;
  endfunction
  always @(negedge clk) check("thermo", 96'(thermo(bus.nreset_out)), 96'd1);
  initial begin
    logic [3:0] pat;
    bus.run_req = 1'b0;
    bus.dly     = 16'd3;
    bus.cfg_in  = '0;
    #2;
    check("rst_nrst", 96'(bus.nreset_out), 96'h0);
    check("rst_running", 96'(bus.running), 96'd0);
    check("rst_busy", 96'(bus.busy), 96'd0);
    check("rst_cfg", bus.cfg_out, 96'h0);
    tick(2);
    rst = 1'b0;
    bus.cfg_in = CFG_A;
    tick();
    check("cfg_follow", bus.cfg_out, CFG_A);
    // bring-up D=3, dly changed after the first release must not matter
    bus.run_req = 1'b1;
    tick();
    check("up_busy", 96'(bus.busy), 96'd1);
    check("up_nrst0", 96'(bus.nreset_out), 96'h0);
    pat = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      tick(3);
      check("up_hold", 96'(bus.nreset_out), 96'(pat));
      tick();
      pat = {pat[2:0], 1'b1};
      check("up_step", 96'(bus.nreset_out), 96'(pat));
      if (k == 0) bus.dly = 16'd9;
    end
    check("run_running", 96'(bus.running), 96'd1);
    check("run_busy", 96'(bus.busy), 96'd0);
    bus.cfg_in = CFG_B;
    tick();
    check("run_cfg_frozen", bus.cfg_out, CFG_A);
    // tear-down D=3
    bus.dly = 16'd3;
    bus.run_req = 1'b0;
    tick();
    check("dn_running", 96'(bus.running), 96'd0);
    check("dn_busy", 96'(bus.busy), 96'd1);
    check("dn_nrst_first", 96'(bus.nreset_out), 96'hF);
    for (int k = 0; k < 4; k++) begin
      tick(4);
      pat = {1'b0, pat[3:1]};
      check("dn_step", 96'(bus.nreset_out), 96'(pat));
    end
    check("off_busy", 96'(bus.busy), 96'd0);
    check("off_cfg_hold", bus.cfg_out, CFG_A);
    tick();
    check("off_cfg_update", bus.cfg_out, CFG_B);
    // abort mid-UP, D=2
    bus.dly = 16'd2;
    bus.run_req = 1'b1;
    tick(7);
    check("ab_0011", 96'(bus.nreset_out), 96'h3);
    bus.run_req = 1'b0;
    tick();
    check("ab_edge", 96'(bus.nreset_out), 96'h3);
    check("ab_busy", 96'(bus.busy), 96'd1);
    tick();
    check("ab_no_0111", 96'(bus.nreset_out), 96'h3);
    tick();
    check("ab_hold", 96'(bus.nreset_out), 96'h3);
    tick();
    check("ab_0001", 96'(bus.nreset_out), 96'h1);
    tick(2);
    check("ab_hold1", 96'(bus.nreset_out), 96'h1);
    tick();
    check("ab_0000", 96'(bus.nreset_out), 96'h0);
    check("ab_off", 96'(bus.busy), 96'd0);
    // abort before any release goes straight to OFF
    bus.dly = 16'd5;
    bus.run_req = 1'b1;
    tick();
    bus.run_req = 1'b0;
    tick();
    check("ab0_busy", 96'(bus.busy), 96'd0);
    check("ab0_nrst", 96'(bus.nreset_out), 96'h0);
    // D=0 gives one-cycle spacing
    bus.dly = 16'd0;
    bus.run_req = 1'b1;
    tick();
    pat = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      tick();
      pat = {pat[2:0], 1'b1};
      check("d0_step", 96'(bus.nreset_out), 96'(pat));
    end
    check("d0_running", 96'(bus.running), 96'd1);
    bus.run_req = 1'b0;
    tick(5);
    check("d0_down", 96'(bus.nreset_out), 96'h0);
    check("d0_busy", 96'(bus.busy), 96'd0);
    // async reset in UP at 0111, then fresh bring-up
    bus.dly = 16'd1;
    bus.run_req = 1'b1;
    tick(7);
    check("ar_0111", 96'(bus.nreset_out), 96'h7);
    #2;
    rst = 1'b1;
    #1;
    check("ar_nrst", 96'(bus.nreset_out), 96'h0);
    check("ar_running", 96'(bus.running), 96'd0);
    check("ar_busy", 96'(bus.busy), 96'd0);
    check("ar_cfg", bus.cfg_out, 96'h0);
    rst = 1'b0;
    tick(2);
    check("ar_fresh0", 96'(bus.nreset_out), 96'h0);
    tick();
    check("ar_fresh1", 96'(bus.nreset_out), 96'h1);
    // maximum delay
    rst = 1'b1;
    #1;
    rst = 1'b0;
    bus.dly = 16'hFFFF;
    tick();
    tick(65535);
    check("dmax_hold", 96'(bus.nreset_out), 96'h0);
    tick();
    check("dmax_bit0", 96'(bus.nreset_out), 96'h1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
